// File: rtl/i3c_xfer_ctrl.sv
// i3c_xfer_ctrl: I3C master transfer sequencer driving START/ADDR/ACK/DATA/STOP phases on SDA
module i3c_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [6:0]            cmd_addr_i,
  input  logic                  cmd_rnw_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe_o,
  output logic                  bit_tick_o,
  output logic [2:0]            state_o,
  output logic                  done_o,
  output logic [1:0]            err_o
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int NB = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_AACK  = 3'd3,
    S_DATA  = 3'd4,
    S_DACK  = 3'd5,
    S_STOP  = 3'd6
  } state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [7:0]            ash_q, ash_d;
  logic [DATA_WIDTH-1:0] dsh_q, dsh_d;
  logic                  rnw_q, rnw_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic                  tick, entry, wtake;
  logic [DATA_WIDTH-1:0] cur;
  // Phase sequencing, bit-period divider, shift registers and byte accounting
  always_comb begin
    tick = state_q != S_IDLE && cnt_q == CW'(CLK_DIV - 1);
    entry = state_q == S_DATA && cnt_q == '0 && bcnt_q == '0;
    wtake = entry && !rnw_q && wdata_valid_i;
    cur = wtake ? wdata_i : dsh_q;
    state_d = state_q;
    cnt_d = (tick || state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
    bcnt_d = bcnt_q;
    ash_d = ash_q;
    dsh_d = dsh_q;
    rnw_d = rnw_q;
    rem_d = rem_q;
    err_d = err_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        ash_d = {cmd_addr_i, cmd_rnw_i};
        rnw_d = cmd_rnw_i;
        rem_d = cmd_len_i;
        err_d = 2'd0;
        state_d = S_START;
      end
      S_START: if (tick) state_d = S_ADDR;
      S_ADDR: if (tick) begin
        ash_d = ash_q << 1;
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BW'(7)) state_d = S_AACK;
      end
      S_AACK: if (tick) begin
        err_d = sda_i ? 2'd1 : 2'd0;
        state_d = (sda_i || rem_q == '0) ? S_STOP : S_DATA;
      end
      S_DATA: if (entry && !rnw_q && !wdata_valid_i) begin
        err_d = 2'd3;
        state_d = S_STOP;
      end else begin
        if (wtake) dsh_d = wdata_i;
        if (tick) begin
          dsh_d = rnw_q ? {dsh_q[DATA_WIDTH-2:0], sda_i} : dsh_q << 1;
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(DATA_WIDTH - 1)) begin
            state_d = S_DACK;
            rdata_d = rnw_q ? {dsh_q[DATA_WIDTH-2:0], sda_i} : rdata_q;
            rvalid_d = rnw_q;
          end
        end
      end
      S_DACK: if (tick) begin
        if (!rnw_q && sda_i) begin
          err_d = 2'd2;
          state_d = S_STOP;
        end else begin
          rem_d = rem_q - LEN_WIDTH'(1);
          state_d = rem_q == LEN_WIDTH'(1) ? S_STOP : S_DATA;
        end
      end
      S_STOP: if (tick) begin
        state_d = S_IDLE;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      bcnt_d = '0;
    end
  end
  // SDA drive: master owns the line except while the target acks or sends read data
  always_comb begin
    sda_oe_o = state_q == S_START || state_q == S_ADDR || state_q == S_STOP ||
               (state_q == S_DATA && !rnw_q) || (state_q == S_DACK && rnw_q);
    sda_o = (state_q == S_START || state_q == S_STOP) ? 1'b0 :
            state_q == S_ADDR ? ash_q[7] :
            (state_q == S_DATA && !rnw_q) ? cur[DATA_WIDTH-1] :
            (state_q == S_DACK && rnw_q) ? rem_q == LEN_WIDTH'(1) : 1'b1;
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bcnt_q <= '0;
      ash_q <= '0;
      dsh_q <= '0;
      rnw_q <= 1'b0;
      rem_q <= '0;
      err_q <= 2'd0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      ash_q <= ash_d;
      dsh_q <= dsh_d;
      rnw_q <= rnw_d;
      rem_q <= rem_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q <= done_d;
    end
  end
  assign cmd_ready_o = state_q == S_IDLE;
  assign wdata_ready_o = wtake;
  assign rdata_o = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign bit_tick_o = tick;
  assign state_o = state_q;
  assign done_o = done_q;
  assign err_o = done_q ? err_q : 2'd0;
endmodule

// File: tb/tb_i3c_xfer_ctrl.sv
// tb_i3c_xfer_ctrl: scoreboard bench with a transaction-level model and a behavioural I3C target
module tb_i3c_xfer_ctrl;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [6:0] cmd_addr_i = '0;
  logic       cmd_rnw_i = 1'b0;
  logic [3:0] cmd_len_i = '0;
  logic [7:0] wdata_i = '0;
  logic       wdata_valid_i = 1'b0;
  logic       wdata_ready_o;
  logic [7:0] rdata_o;
  logic       rdata_valid_o;
  logic       sda_i = 1'b1;
  logic       sda_o;
  logic       sda_oe_o;
  logic       bit_tick_o;
  logic [2:0] state_o;
  logic       done_o;
  logic [1:0] err_o;

  i3c_xfer_ctrl #(.DATA_WIDTH(8), .LEN_WIDTH(4), .CLK_DIV(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_rnw_i(cmd_rnw_i), .cmd_len_i(cmd_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .sda_i(sda_i), .sda_o(sda_o),
    .sda_oe_o(sda_oe_o), .bit_tick_o(bit_tick_o), .state_o(state_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] st; logic oe; logic sda;} tk_t;
  typedef struct {int t; logic [1:0] err; int nwr;} dn_t;
  tk_t        exp_tk[$];
  logic [7:0] exp_rd[$];
  dn_t        exp_done[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nwr = 0;
  bit mon_en = 1'b0;
  logic [6:0] p_addr;
  logic       p_rnw = 1'b0;
  logic       p_anack = 1'b0;
  int         p_len = 0;
  int         p_nack = -1;
  int         p_navail = 0;
  logic [7:0] p_wb[16];
  logic [7:0] p_rb[16];
  logic [7:0] s_wb[16];
  logic [7:0] s_rb[16];
  int bi = 0;
  int by = 0;
  int wi = 0;
  tk_t mon_e;
  dn_t mon_d;
  logic [7:0] mon_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {state_o, cmd_ready_o, sda_o, sda_oe_o, wdata_ready_o, rdata_valid_o,
               bit_tick_o, done_o, rdata_o, err_o},
        {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
  endtask

  task automatic push_tk(input logic [2:0] st, input logic oe, input logic sda);
    tk_t e;
    e.st = st;
    e.oe = oe;
    e.sda = sda;
    exp_tk.push_back(e);
  endtask

  // Reference: one expected tick per bit period, read bytes, and the completion record
  task automatic model(input int t);
    logic [7:0] a8;
    logic [7:0] w;
    logic [1:0] err;
    int p;
    int nw;
    int extra;
    dn_t d;
    a8 = {p_addr, p_rnw};
    p = 0; err = 2'd0; nw = 0; extra = 0;
    push_tk(3'd1, 1'b1, 1'b0); p++;
    for (int i = 0; i < 8; i++) begin push_tk(3'd2, 1'b1, a8[7-i]); p++; end
    push_tk(3'd3, 1'b0, 1'b0); p++;
    if (p_anack) err = 2'd1;
    else begin
      for (int b = 0; b < p_len; b++) begin
        if (!p_rnw && b >= p_navail) begin err = 2'd3; extra = 1; break; end
        w = p_wb[b];
        for (int i = 0; i < 8; i++) begin push_tk(3'd4, !p_rnw, p_rnw ? 1'b0 : w[7-i]); p++; end
        if (p_rnw) exp_rd.push_back(p_rb[b]);
        else nw++;
        push_tk(3'd5, p_rnw, p_rnw && (b == p_len - 1)); p++;
        if (!p_rnw && b == p_nack) begin err = 2'd2; break; end
      end
    end
    push_tk(3'd6, 1'b1, 1'b0); p++;
    d.t = t + p * D + 1 + extra;
    d.err = err;
    d.nwr = nw;
    exp_done.push_back(d);
  endtask

  task automatic issue(input logic [6:0] a, input logic rnw, input int len, input logic anack,
                       input int nack, input int navail, input bit push);
    int n = 0;
    while (!cmd_ready_o && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("ready_timeout", {31'd0, cmd_ready_o}, 1);
    p_addr = a; p_rnw = rnw; p_len = len; p_anack = anack; p_nack = nack; p_navail = navail;
    for (int i = 0; i < 16; i++) begin p_wb[i] = s_wb[i]; p_rb[i] = s_rb[i]; end
    cmd_addr_i = a; cmd_rnw_i = rnw; cmd_len_i = 4'(len); cmd_valid_i = 1'b1;
    if (push) model(cyc);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin s_wb[i] = 8'($urandom); s_rb[i] = 8'($urandom); end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_done.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    chk("drain_done", exp_done.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT ticks, delivers read data or completes
  always @(negedge clk) if (mon_en) begin
    if (bit_tick_o) begin
      if (exp_tk.size() == 0) chk("tick_unexpected", {31'd0, bit_tick_o}, 0);
      else begin
        mon_e = exp_tk.pop_front();
        chk("tick_state", state_o, mon_e.st);
        chk("tick_oe", sda_oe_o, mon_e.oe);
        if (mon_e.oe) chk("tick_sda", sda_o, mon_e.sda);
      end
    end
    if (rdata_valid_o) begin
      if (exp_rd.size() == 0) chk("rdata_unexpected", {31'd0, rdata_valid_o}, 0);
      else begin mon_r = exp_rd.pop_front(); chk("rdata", rdata_o, mon_r); end
    end
    if (wdata_ready_o) nwr++;
    if (done_o) begin
      if (exp_done.size() == 0) chk("done_unexpected", {31'd0, done_o}, 0);
      else begin
        mon_d = exp_done.pop_front();
        chk("done_cycle", cyc, mon_d.t);
        chk("done_err", err_o, mon_d.err);
        chk("wdata_ready_count", nwr, mon_d.nwr);
      end
      nwr = 0;
    end
  end

  // Target and write-data source: valid SDA only on tick cycles, noise elsewhere
  always @(negedge clk) begin
    if (state_o == 3'd0 || state_o == 3'd1) begin bi = 0; by = 0; wi = 0; end
    sda_i = 1'($urandom);
    if (bit_tick_o) begin
      if (state_o == 3'd3) sda_i = p_anack;
      else if (state_o == 3'd4 && p_rnw) sda_i = p_rb[by][7-bi];
      else if (state_o == 3'd5 && !p_rnw) sda_i = (by == p_nack);
      if (state_o == 3'd4) bi++;
      if (state_o == 3'd5) begin by++; bi = 0; end
    end
    wdata_i = p_wb[wi];
    wdata_valid_i = wi < p_navail;
    if (wdata_ready_o) wi++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int nack;
    int nav;
    logic rnw;
    fill_rand();
    for (int i = 0; i < 16; i++) begin p_wb[i] = s_wb[i]; p_rb[i] = s_rb[i]; end
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk_reset("reset_state");
    mon_en = 1'b1;
    fill_rand(); s_wb[0] = 8'hA5;
    issue(7'h2A, 1'b0, 1, 1'b0, -1, 1, 1'b1);
    fill_rand(); s_rb[0] = 8'h3C; s_rb[1] = 8'hF0;
    issue(7'h50, 1'b1, 2, 1'b0, -1, 0, 1'b1);
    fill_rand();
    issue(7'h11, 1'b0, 2, 1'b1, -1, 2, 1'b1);
    fill_rand();
    issue(7'h33, 1'b0, 3, 1'b0, 1, 3, 1'b1);
    fill_rand();
    issue(7'h44, 1'b0, 1, 1'b0, -1, 0, 1'b1);
    fill_rand();
    issue(7'h7E, 1'b1, 0, 1'b0, -1, 0, 1'b1);
    fill_rand();
    issue(7'h01, 1'b0, 15, 1'b0, -1, 15, 1'b1);
    fill_rand();
    issue(7'h02, 1'b1, 15, 1'b0, -1, 0, 1'b1);
    drain();
    mon_en = 1'b0;
    fill_rand();
    issue(7'h55, 1'b0, 2, 1'b0, -1, 2, 1'b0);
    begin
      int n = 0;
      while (state_o != 3'd2 && n < 100) begin @(negedge clk); n++; end
    end
    chk("reach_addr", state_o, 3'd2);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk_reset("reset_mid_addr");
    nwr = 0;
    mon_en = 1'b1;
    fill_rand();
    issue(7'h5A, 1'b1, 2, 1'b0, -1, 0, 1'b1);
    cmd_valid_i = 1'b1; cmd_addr_i = 7'h7F; cmd_rnw_i = 1'b0; cmd_len_i = 4'd3;
    repeat (3) @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 25; k++) begin
      fill_rand();
      rnw = 1'($urandom);
      len = $urandom_range(0, 5);
      nack = (!rnw && $urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      nav = (!rnw && $urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
      issue(7'($urandom), rnw, len, $urandom_range(0, 7) == 0, nack, nav, 1'b1);
    end
    drain();
    chk("drain_ticks", exp_tk.size(), 0);
    chk("drain_rdata", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
